// File: rtl/step_pkg.sv
// Shared types and default constants for the step counter.
package step_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   localparam int unsigned SAT_MAX_DEF    = 9999;
   localparam int unsigned ACT_THRESH_DEF = 32;
   localparam logic [7:0]  WIN_MAX        = 8'd255;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for the raw step pulse.
module pulse_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= async_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/step_counter.sv
// Pedometer core: run/hold session control, saturating step total and per-second rate windows.
module step_counter
   import step_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100000000,
   parameter int unsigned SAT_MAX    = SAT_MAX_DEF,
   parameter int unsigned ACT_THRESH = ACT_THRESH_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        pulse,
   output logic [15:0] stepcount,
   output logic [7:0]  steps_per_sec,
   output logic [15:0] active_secs,
   output logic        overflow,
   output logic        running
);

   localparam int unsigned TW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [TW-1:0] T_MAX = TW'(CLK_HZ - 1);
   localparam logic [15:0] SAT_VAL = 16'(SAT_MAX);

   state_e        r_state;
   state_e        w_state_nxt;
   logic [TW-1:0] r_timer;
   logic [7:0]    r_win;
   logic [15:0]   r_steps;
   logic [7:0]    r_sps;
   logic [15:0]   r_act;
   logic          r_ovf;

   logic          w_rise;
   logic          w_step;
   logic          w_win_end;
   logic          w_clear;
   logic [7:0]    w_win_incl;

   pulse_sync_edge u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (pulse),
      .rise     (w_rise)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_nxt = RUN;
         RUN:     if (start) w_state_nxt = HOLD;
         HOLD:    if (start) w_state_nxt = RUN;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_step    = w_rise && (r_state == RUN);
   assign w_win_end = (r_state == RUN) && (r_timer == T_MAX);
   assign w_clear   = (r_state == IDLE) && start;
   // Window total including an edge landing on this cycle, held at 255.
   assign w_win_incl = (w_step && (r_win != WIN_MAX)) ? r_win + 8'd1 : r_win;

   always_ff @(posedge clk) begin
      if (reset || w_clear) begin
         r_timer <= '0;
         r_win   <= '0;
         r_steps <= '0;
         r_sps   <= '0;
         r_act   <= '0;
         r_ovf   <= 1'b0;
      end else if (r_state == RUN) begin
         if (w_step) begin
            if (r_steps == SAT_VAL) r_ovf   <= 1'b1;
            else                    r_steps <= r_steps + 16'd1;
         end
         if (w_win_end) begin
            r_timer <= '0;
            r_sps   <= w_win_incl;
            r_win   <= {7'd0, w_step};
            if ((32'(w_win_incl) >= ACT_THRESH) && (r_act != SAT_VAL)) begin
               r_act <= r_act + 16'd1;
            end
         end else begin
            r_timer <= r_timer + TW'(1);
            r_win   <= w_win_incl;
         end
      end
   end

   assign stepcount     = r_steps;
   assign steps_per_sec = r_sps;
   assign active_secs   = r_act;
   assign overflow      = r_ovf;
   assign running       = (r_state == RUN);

endmodule

// File: tb/tb_step_counter.sv
// Self-checking bench for step_counter: scoreboard on stepcount plus directed window/state checks.
module tb_step_counter;

   localparam int unsigned CLK_HZ     = 10;
   localparam int unsigned SAT_MAX    = 9999;
   localparam int unsigned ACT_THRESH = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        pulse;
   logic [15:0] stepcount;
   logic [7:0]  steps_per_sec;
   logic [15:0] active_secs;
   logic        overflow;
   logic        running;

   step_counter #(
      .CLK_HZ     (CLK_HZ),
      .SAT_MAX    (SAT_MAX),
      .ACT_THRESH (ACT_THRESH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .pulse         (pulse),
      .stepcount     (stepcount),
      .steps_per_sec (steps_per_sec),
      .active_secs   (active_secs),
      .overflow      (overflow),
      .running       (running)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned val;
      int unsigned cyc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int unsigned cyc       = 0;
   int unsigned n_cmp     = 0;
   int unsigned n_err     = 0;
   int unsigned exp_steps = 0;
   int unsigned mode      = 0;  // bench view of DUT state: 0 idle, 1 run, 2 hold
   int unsigned t0;
   int unsigned t1;
   logic [15:0] last_sc   = 16'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Every stepcount change must match the next scoreboard entry, value and cycle.
   always @(negedge clk) begin
      if (stepcount !== last_sc) begin
         if (sb_q.size() == 0) begin
            check("sc_unexpected", {16'd0, stepcount}, {16'd0, last_sc});
         end else begin
            mon_e = sb_q.pop_front();
            check("sc_val", {16'd0, stepcount}, mon_e.val);
            check("sc_lat", cyc, mon_e.cyc);
         end
         last_sc = stepcount;
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input int unsigned c);
      while (cyc < c) tick(1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      if (exp_steps != 0) sb_q.push_back('{val: 0, cyc: cyc + 1});
      exp_steps = 0;
      mode      = 0;
      tick(1);
      reset = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      case (mode)
         0: begin
            if (exp_steps != 0) sb_q.push_back('{val: 0, cyc: cyc + 1});
            exp_steps = 0;
            mode      = 1;
         end
         1:       mode = 2;
         default: mode = 1;
      endcase
      tick(1);
      start = 1'b0;
   endtask

   // Edge is consumed three clock edges after the drive point; only counted in RUN.
   task automatic send_pulse(input int unsigned high, input int unsigned low);
      pulse = 1'b1;
      if (mode == 1 && exp_steps < SAT_MAX) begin
         exp_steps++;
         sb_q.push_back('{val: exp_steps, cyc: cyc + 3});
      end
      tick(high);
      pulse = 1'b0;
      tick(low);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      pulse = 1'b0;
      tick(2);
      check("rst_sc", {16'd0, stepcount}, 0);
      check("rst_sps", {24'd0, steps_per_sec}, 0);
      check("rst_act", {16'd0, active_secs}, 0);
      check("rst_ovf", {31'd0, overflow}, 0);
      check("rst_run", {31'd0, running}, 0);
      reset = 1'b0;
      tick(1);

      // Isolated long pulses: one count each, fixed latency
      do_start();
      check("a_running", {31'd0, running}, 1);
      repeat (5) send_pulse(4, 4);
      tick(4);
      check("a_sc", {16'd0, stepcount}, 5);

      // Window rates: 3 steps then 1 step
      do_reset();
      do_start();
      t0 = cyc;
      repeat (3) send_pulse(1, 1);
      wait_until(t0 + 9);
      check("b_sps_pre", {24'd0, steps_per_sec}, 0);
      wait_until(t0 + 10);
      check("b_sps_w1", {24'd0, steps_per_sec}, 3);
      check("b_act_w1", {16'd0, active_secs}, 1);
      send_pulse(1, 1);
      wait_until(t0 + 20);
      check("b_sps_w2", {24'd0, steps_per_sec}, 1);
      check("b_act_w2", {16'd0, active_secs}, 1);

      // HOLD freezes timer and discards pulses
      do_reset();
      do_start();
      t0 = cyc;
      send_pulse(1, 1);
      wait_until(t0 + 4);
      do_start();
      check("c_hold_run", {31'd0, running}, 0);
      repeat (4) send_pulse(2, 2);
      tick(4);
      check("c_sc_hold", {16'd0, stepcount}, 1);
      check("c_sps_hold", {24'd0, steps_per_sec}, 0);
      do_start();
      t1 = cyc;
      check("c_resume_run", {31'd0, running}, 1);
      send_pulse(1, 1);
      wait_until(t1 + 4);
      check("c_sps_pre", {24'd0, steps_per_sec}, 0);
      wait_until(t1 + 5);
      check("c_sps_end", {24'd0, steps_per_sec}, 2);
      check("c_act_end", {16'd0, active_secs}, 0);

      // Reset mid-window discards partial window
      do_reset();
      do_start();
      t0 = cyc;
      repeat (2) send_pulse(1, 1);
      wait_until(t0 + 7);
      do_reset();
      check("e_sc", {16'd0, stepcount}, 0);
      check("e_sps", {24'd0, steps_per_sec}, 0);
      check("e_act", {16'd0, active_secs}, 0);
      check("e_ovf", {31'd0, overflow}, 0);
      check("e_run", {31'd0, running}, 0);
      repeat (2) send_pulse(2, 2);
      check("e_sps_idle", {24'd0, steps_per_sec}, 0);
      check("e_sc_idle", {16'd0, stepcount}, 0);
      do_start();
      tick(12);
      check("e_sc_run", {16'd0, stepcount}, 0);
      check("e_sps_run", {24'd0, steps_per_sec}, 0);

      // Edge and start both on the window-end cycle
      do_reset();
      do_start();
      t0 = cyc;
      repeat (2) send_pulse(1, 1);
      wait_until(t0 + 7);
      send_pulse(1, 1);
      do_start();
      check("f_sps", {24'd0, steps_per_sec}, 3);
      check("f_act", {16'd0, active_secs}, 1);
      check("f_run", {31'd0, running}, 0);
      check("f_sc", {16'd0, stepcount}, 3);

      // Saturation and sticky overflow
      do_reset();
      do_start();
      repeat (SAT_MAX - 1) send_pulse(1, 1);
      tick(4);
      check("d_sc_pre", {16'd0, stepcount}, SAT_MAX - 1);
      check("d_ovf_pre", {31'd0, overflow}, 0);
      send_pulse(1, 1);
      tick(4);
      check("d_sc_max", {16'd0, stepcount}, SAT_MAX);
      check("d_ovf_max", {31'd0, overflow}, 0);
      repeat (2) send_pulse(1, 1);
      tick(4);
      check("d_sc_sat", {16'd0, stepcount}, SAT_MAX);
      check("d_ovf_set", {31'd0, overflow}, 1);
      do_start();
      do_start();
      tick(2);
      check("d_ovf_sticky", {31'd0, overflow}, 1);
      check("d_run_again", {31'd0, running}, 1);
      check("d_sc_kept", {16'd0, stepcount}, SAT_MAX);

      tick(4);
      check("sb_drain", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
